// File: rtl/lvds_ser_pkg.sv
// Shared types and constants for the LVDS word serializer and its PRBS7 idle filler.
package lvds_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic [6:0] PRBS7_SEED  = 7'h7F;
  localparam int         PRBS7_TAP_A = 6;
  localparam int         PRBS7_TAP_B = 5;

  // Fibonacci step for x^7 + x^6 + 1; the output bit is the MSB of the current state.
  function automatic logic [6:0] prbs7_next(input logic [6:0] state);
    return {state[5:0], state[PRBS7_TAP_A] ^ state[PRBS7_TAP_B]};
  endfunction

endpackage

// File: rtl/lvds_word_serializer_prbs7.sv
// PRBS7 generator used as idle filler; steps only when the caller consumes a bit.
module prbs7_gen
  import lvds_ser_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic bit_out
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = prbs7_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[6];

endmodule

// File: rtl/lvds_word_serializer.sv
// MSB-first word serializer feeding an LVDS output buffer.
// Define LVDS_SER_PRBS_IDLE_EN to fill idle bit periods with PRBS7 instead of constant 0.
module lvds_word_serializer
  import lvds_ser_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               sdo,
  output logic               frame,
  output logic               busy,
  output logic [COUNT_W-1:0] word_count
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  ser_state_e         state_q, state_d;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;
  // MSB goes straight to sdo on load, so only the remaining WIDTH-1 bits are held.
  logic [WIDTH-2:0]   shift_q, shift_d;
  logic               sdo_q, sdo_d;
  logic               frame_q, frame_d;
  logic               busy_q, busy_d;
  logic [COUNT_W-1:0] word_count_q, word_count_d;
  logic               rst_done_q, rst_done_d;

  logic               last_bit;
  logic               ready_c;
  logic               xfer;
  logic               idle_bit;

  assign last_bit = (state_q == SHIFT) && (bitcnt_q == LAST_BIT);
  assign ready_c  = rst_done_q && ((state_q == IDLE) || last_bit);
  assign xfer     = in_valid && ready_c;

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    sdo_d        = sdo_q;
    frame_d      = 1'b0;
    busy_d       = busy_q;
    word_count_d = word_count_q;
    rst_done_d   = 1'b1;

    if (xfer) begin
      state_d  = SHIFT;
      shift_d  = in_data[WIDTH-2:0];
      sdo_d    = in_data[WIDTH-1];
      frame_d  = 1'b1;
      bitcnt_d = '0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (last_bit) begin
            state_d = IDLE;
            sdo_d   = idle_bit;
            busy_d  = 1'b0;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
            sdo_d    = shift_q[WIDTH-2];
            shift_d  = shift_q << 1;
          end
        end
        default: begin
          state_d = IDLE;
          sdo_d   = idle_bit;
          busy_d  = 1'b0;
        end
      endcase
    end

    // The word completes on its final bit edge whether or not another follows.
    if (last_bit) begin
      word_count_d = word_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      sdo_q        <= 1'b0;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
      word_count_q <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      sdo_q        <= sdo_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
      word_count_q <= word_count_d;
      rst_done_q   <= rst_done_d;
    end
  end

`ifdef LVDS_SER_PRBS_IDLE_EN
  // An idle bit is emitted exactly on the edges that land in IDLE.
  logic prbs_advance;
  assign prbs_advance = (state_d == IDLE);

  prbs7_gen u_prbs7 (
    .clk     (clk),
    .rst     (rst),
    .advance (prbs_advance),
    .bit_out (idle_bit)
  );
`else
  assign idle_bit = 1'b0;
`endif

  assign in_ready   = ready_c;
  assign sdo        = sdo_q;
  assign frame      = frame_q;
  assign busy       = busy_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_lvds_word_serializer.sv
// Directed self-checking bench for lvds_word_serializer (default and 4-bit counter instances).
module tb_lvds_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic        in_ready, sdo, frame, busy;
  logic [15:0] word_count;
  logic        in_ready4, sdo4, frame4, busy4;
  logic [3:0]  word_count4;

  int         checks = 0;
  int         errors = 0;
  int         exp_count = 0;
  bit         pending_done = 1'b0;
  logic [6:0] ref_lfsr = 7'h7F;

  always #5 clk = ~clk;

  lvds_word_serializer #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sdo(sdo), .frame(frame), .busy(busy),
    .word_count(word_count)
  );

  lvds_word_serializer #(.WIDTH(8), .COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .sdo(sdo4), .frame(frame4), .busy(busy4),
    .word_count(word_count4)
  );

  function automatic logic idle_exp();
`ifdef LVDS_SER_PRBS_IDLE_EN
    return ref_lfsr[6];
`else
    return 1'b0;
`endif
  endfunction

  task automatic advance_idle();
    ref_lfsr = {ref_lfsr[5:0], ref_lfsr[6] ^ ref_lfsr[5]};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_count(input string tag);
    logic [31:0] e16, e4;
    e16 = 32'(exp_count[15:0]);
    e4  = 32'(exp_count[3:0]);
    check({tag, "_wc"}, 32'(word_count), e16);
    check({tag, "_wc4"}, 32'(word_count4), e4);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    exp_count    = 0;
    pending_done = 1'b0;
    ref_lfsr     = 7'h7F;
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    chk_count("rst");
    for (int i = 0; i < n; i++) begin
      tick();
      check("rst_ready_hold", 32'(in_ready), 32'd0);
    end
    rst = 1'b1;
    tick();
    check("post_rst_sdo", 32'(sdo), 32'(idle_exp()));
    advance_idle();
    check("post_rst_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    $display("reset released after %0d held cycles", n);
  endtask

  task automatic send_word(input logic [7:0] d, input bit last);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        if (last) in_valid = 1'b0;
        if (pending_done) exp_count++;
        pending_done = 1'b0;
        chk_count("load");
      end
      check("sdo_bit", 32'(sdo), 32'(d[7-i]));
      check("frame", 32'(frame), 32'(i == 0));
      check("busy", 32'(busy), 32'd1);
      check("ready_shift", 32'(in_ready), 32'(i == 7));
    end
    pending_done = 1'b1;
    $display("word %02h shifted out, last=%0d", d, last);
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (pending_done) exp_count++;
      pending_done = 1'b0;
      check("idle_sdo", 32'(sdo), 32'(idle_exp()));
      advance_idle();
      check("idle_frame", 32'(frame), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd1);
      chk_count("idle");
    end
    $display("%0d idle bits checked, word_count=%0d", n, word_count);
  endtask

  initial begin
    // Reset with a word already offered, then a single word.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    do_reset(3);
    send_word(8'hA5, 1'b1);
    expect_idle(2);

    // Back-to-back stream.
    do_reset(2);
    send_word(8'h3C, 1'b0);
    send_word(8'hFF, 1'b0);
    send_word(8'h01, 1'b1);
    expect_idle(1);
    check("b2b_count", 32'(word_count), 32'd3);

    // Source stall after a single word.
    send_word(8'h80, 1'b1);
    expect_idle(5);
    check("stall_count", 32'(word_count), 32'd4);

    // Reset in the middle of a word.
    in_data  = 8'hF0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_bit0", 32'(sdo), 32'd1);
    check("mid_frame0", 32'(frame), 32'd1);
    tick();
    tick();
    check("mid_bit2", 32'(sdo), 32'd1);
    do_reset(2);
    send_word(8'h5A, 1'b1);
    expect_idle(1);
    check("after_mid_count", 32'(word_count), 32'd1);

    // Counter wrap on the 4-bit instance.
    do_reset(1);
    for (int k = 0; k < 17; k++) begin
      send_word(8'h55, k == 16);
    end
    expect_idle(1);
    check("wrap_wc4", 32'(word_count4), 32'd1);
    check("wrap_wc16", 32'(word_count), 32'd17);

    // Long idle run, then a word inserted mid-stream.
    do_reset(1);
    expect_idle(130);
    send_word(8'hC3, 1'b1);
    expect_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
